// File: rtl/clint_timer_if.sv
// Request/response bus between the core's data-side MMIO port and the CLINT block.
interface clint_timer_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic [7:0]        req_wstrb_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/clint_timer.sv
// CLINT machine timer / software interrupt register block (msip, mtimecmp, mtime).
// Optional debug halt of mtime via macro CLINT_MTIME_STOP_EN (adds port mtime_stop_i).
module clint_timer #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CLINT_MTIME_STOP_EN
  input  logic          mtime_stop_i,
`endif
  clint_timer_if.slave  bus,
  output logic          timer_irq_o,
  output logic          soft_irq_o
);

  localparam logic [ADDR_W-1:0] AddrMsip     = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] AddrMtimecmp = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] AddrMtime    = ADDR_W'(16'hBFF8);

  localparam int unsigned       PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e            r_state, w_state_d;
  logic              r_msip;
  logic [XLEN-1:0]   r_mtimecmp, w_mtimecmp_d;
  logic [XLEN-1:0]   r_mtime, w_mtime_d;
  logic [PrescW-1:0] r_presc, w_presc_d;
  logic              r_timer_irq;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_sel_msip, w_sel_cmp, w_sel_time, w_hit;
  logic              w_wr;
  logic [XLEN-1:0]   w_rdata;
  logic              w_run, w_tick;

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] new_v,
                                                  input logic [7:0]      strb);
    logic [XLEN-1:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

`ifdef CLINT_MTIME_STOP_EN
  assign w_run = ~mtime_stop_i;
`else
  assign w_run = 1'b1;
`endif

  // Exact offset match also rejects any misaligned address.
  assign w_sel_msip = (bus.req_addr_i == AddrMsip);
  assign w_sel_cmp  = (bus.req_addr_i == AddrMtimecmp);
  assign w_sel_time = (bus.req_addr_i == AddrMtime);
  assign w_hit      = w_sel_msip | w_sel_cmp | w_sel_time;

  assign w_accept = (r_state == StIdle) & bus.req_valid_i;
  assign w_wr     = w_accept & bus.req_write_i & w_hit;

  always_comb begin
    w_rdata = '0;
    if (w_sel_msip) begin
      w_rdata = {{(XLEN-1){1'b0}}, r_msip};
    end else if (w_sel_cmp) begin
      w_rdata = r_mtimecmp;
    end else if (w_sel_time) begin
      w_rdata = r_mtime;
    end
  end

  assign w_tick = w_run & (r_presc == PrescMax);

  always_comb begin
    w_presc_d = r_presc;
    if (w_tick) begin
      w_presc_d = '0;
    end else if (w_run) begin
      w_presc_d = r_presc + 1'b1;
    end
  end

  // A write to mtime suppresses that cycle's increment; unwritten bytes keep pre-tick value.
  always_comb begin
    w_mtime_d = r_mtime;
    if (w_wr && w_sel_time && (|bus.req_wstrb_i)) begin
      w_mtime_d = merge_bytes(r_mtime, bus.req_wdata_i, bus.req_wstrb_i);
    end else if (w_tick) begin
      w_mtime_d = r_mtime + 64'd1;
    end
  end

  always_comb begin
    w_mtimecmp_d = r_mtimecmp;
    if (w_wr && w_sel_cmp) begin
      w_mtimecmp_d = merge_bytes(r_mtimecmp, bus.req_wdata_i, bus.req_wstrb_i);
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.req_valid_i) w_state_d = StResp;
      StResp:  if (bus.resp_ready_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_msip      <= 1'b0;
      r_mtimecmp  <= '1;
      r_mtime     <= '0;
      r_presc     <= '0;
      r_timer_irq <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_mtimecmp  <= w_mtimecmp_d;
      r_mtime     <= w_mtime_d;
      r_presc     <= w_presc_d;
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      if (w_wr && w_sel_msip && bus.req_wstrb_i[0]) begin
        r_msip <= bus.req_wdata_i[0];
      end
      if (w_accept) begin
        r_rdata <= (bus.req_write_i || !w_hit) ? '0 : w_rdata;
        r_err   <= ~w_hit;
      end
    end
  end

  assign bus.req_ready_o  = (r_state == StIdle);
  assign bus.resp_valid_o = (r_state == StResp);
  assign bus.resp_rdata_o = r_rdata;
  assign bus.resp_err_o   = r_err;
  assign timer_irq_o      = r_timer_irq;
  assign soft_irq_o       = r_msip;

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer and software-interrupt source (CLINT register block).
- Sits on the core's data-side MMIO port, in parallel with data memory.
- Drives the machine timer and software interrupt request lines into the trap/interrupt controller, which takes the trap, writes mepc/mcause and redirects fetch to mtvec.
- Holds msip, mtimecmp and a free-running mtime counter; single-outstanding valid/ready request/response slave.

Parameters:
- XLEN, 64, register/data width; fixed at 64 for this block.
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.
- ADDR_W, 16, width of the block-local byte offset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid&ready.
- req_write_i  input  1  1=write, 0=read.
- req_addr_i  input  ADDR_W  byte offset, 8-byte aligned.
- req_wdata_i  input  XLEN  write data.
- req_wstrb_i  input  8  byte write enables.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  response consumed when valid&ready.
- resp_rdata_o  output  XLEN  read data; 0 for writes and errors.
- resp_err_o  output  1  unmapped or misaligned access.
- timer_irq_o  output  1  machine timer interrupt pending (MTIP).
- soft_irq_o  output  1  machine software interrupt pending (MSIP).

Behaviour:
- Register map:
  - 0x0000 msip: only bit0 is implemented; bits 63:1 read 0 and ignore writes.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other offset, or addr[2:0]!=0, is an error.
- Reset values (rst low, asynchronous):
  - msip=0, mtimecmp=all ones, mtime=0, prescaler=0.
  - FSM=IDLE; req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - timer_irq_o=0, soft_irq_o=0.
- FSM:
  - IDLE: req_ready_o=1. On req_valid_i, perform the access in that cycle's clock edge, register the response, go to RESP.
  - RESP: resp_valid_o=1, req_ready_o=0. rdata/err are held stable until resp_ready_i. On resp_ready_i, return to IDLE; the next request is accepted no earlier than the following cycle.
  - Latency: request accepted in cycle N gives resp_valid_o in cycle N+1.
- Reads return the register value at the accept edge, before any same-cycle tick.
- Writes update only bytes whose wstrb bit is set; wstrb=0 is a legal no-op with err=0.
- Error accesses: no state change, rdata=0, err=1.
- Prescaler and mtime:
  - The prescaler counts 0..TICK_DIV-1.
  - On wrap, mtime increments by 1 modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF+1 -> 0.
  - TICK_DIV=1 increments every cycle.
- Simultaneous mtime write and tick: the write wins for written bytes; unwritten bytes keep their pre-tick value (no increment that cycle). The prescaler is not reset by mtime writes.
- timer_irq_o = registered (mtime >= mtimecmp), unsigned 64-bit compare. Updated every cycle, so it lags the compare inputs by 1 cycle. It is level-sensitive and clears only when mtimecmp is raised or mtime is rewritten below it.
- soft_irq_o = msip[0], registered, visible the cycle after the write edge.
- Reset mid-transaction: any pending response is dropped and the FSM returns to IDLE.

Optional Feature:
- Macro: CLINT_MTIME_STOP_EN.
- Defined: adds input port mtime_stop_i (1 bit, debug halt).
  - While high, the prescaler and mtime hold.
  - Register writes to mtime still take effect.
  - The compare keeps evaluating.
- Undefined: no such port; mtime always counts.

Test Plan:
- Reset, then read 0xBFF8 at once with TICK_DIV=1 -> resp next cycle, rdata equals the elapsed cycle count; timer_irq_o=0, since mtimecmp reads all ones.
- Write mtimecmp=0x20, mtime=0x10 (wstrb=0xFF) -> timer_irq_o rises exactly 0x10 ticks plus 1 cycle after the mtime write. A later write of mtimecmp=0x1000 drops timer_irq_o 1 cycle after the write edge.
- Write msip wdata=0xFFFF_FFFF_FFFF_FFFF -> soft_irq_o=1; read back gives 0x1. Write 0 -> soft_irq_o=0.
- Write mtime=0xFFFF_FFFF_FFFF_FFFE, wait 2 ticks -> read 0x0 (wrap). Separately, write wstrb=0x01 data 0xAB to mtime=0 in a tick cycle -> mtime=0xAB.
- Read 0x0008, and write 0x4004 -> err=1, rdata=0, no register change. Holding resp_ready_i low for 3 cycles keeps resp_valid_o high with stable data, and req_ready_o=0 throughout.
- With CLINT_MTIME_STOP_EN, assert mtime_stop_i for 10 cycles -> mtime unchanged across that window. TICK_DIV=4 -> mtime +1 every 4 cycles.
